apb_reg_slave: RTL

Parametrised APB4 completer with an internal register file. Generalises the existing fixed-width APB interface into a synthesizable slave with configurable width, register count, wait states, byte strobes, read-only status registers and error response. Sits behind the APB bridge and drives/collects control and status bits for a peripheral.

---
 rtl/apb_reg_pkg.sv | 15 +
 rtl/apb_access_fsm.sv | 56 +++++
 rtl/apb_reg_slave.sv | 89 ++++++++
 3 files changed

// File: rtl/apb_reg_pkg.sv
// Shared types and helpers for the APB register slave.
package apb_reg_pkg;
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;

  localparam int CNT_W = 4;

  function automatic int lsb_of(input int dw);
    return (dw == 8) ? 0 : (dw == 16) ? 1 : 2;
  endfunction

  function automatic logic acc_err(input logic idx_oob, input logic off_nz,
                                   input logic wr, input logic ro);
    return idx_oob | off_nz | (wr & ro);
  endfunction
endpackage

// File: rtl/apb_access_fsm.sv
// APB transfer sequencer: setup/access tracking, wait-state countdown,
// completion and abort strobes.
module apb_access_fsm
  import apb_reg_pkg::*;
#(
  parameter int WAIT_CYC = 0
) (
  input  logic pclk,
  input  logic preset_n,
  input  logic psel,
  input  logic penable,
  output logic pready,
  output logic complete,
  output logic abort
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = ACCESS;
          cnt_d   = CNT_W'(WAIT_CYC);
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (penable) begin
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gated by reset so a transfer in flight never completes while reset is held.
  assign pready   = preset_n & (state_q == ACCESS) & (cnt_q == '0);
  assign complete = pready & psel & penable;
  assign abort    = (state_q == ACCESS) & ~psel;
endmodule

// File: rtl/apb_reg_slave.sv
// APB4 completer with a byte-strobed RW register file, read-only status
// slots and error response for bad index, misalignment or RO writes.
module apb_reg_slave
  import apb_reg_pkg::*;
#(
  parameter int              AW       = 6,
  parameter int              DW       = 32,
  parameter int              NREG     = 16,
  parameter int              WAIT_CYC = 0,
  parameter logic [NREG-1:0] RO_MASK  = '0,
  parameter logic [DW-1:0]   RST_VAL  = '0
) (
  input  logic               pclk,
  input  logic               preset_n,
  input  logic               psel,
  input  logic               penable,
  input  logic [AW-1:0]      paddr,
  input  logic               pwrite,
  input  logic [DW-1:0]      pwdata,
  input  logic [DW/8-1:0]    pstrb,
  output logic [DW-1:0]      prdata,
  output logic               pready,
  output logic               pslverr,
  output logic [NREG*DW-1:0] reg_o,
  input  logic [NREG*DW-1:0] sts_i
);
  localparam int              LSB      = lsb_of(DW);
  localparam int              IW       = AW - LSB;
  localparam int              NB       = DW / 8;
  localparam int              RO_W     = 2 ** IW;
  localparam logic [IW:0]     NREG_V   = (IW + 1)'(NREG);
  localparam logic [AW-1:0]   OFF_MASK = AW'((1 << LSB) - 1);

  logic                      complete, abort;
  logic [IW-1:0]             idx;
  logic                      idx_oob, off_nz, err, wr_en;
  logic [RO_W-1:0]           ro_ext;
  logic [DW-1:0]             rd_sel;
  logic [NREG-1:0][DW-1:0]   reg_q, reg_d;

  apb_access_fsm #(.WAIT_CYC(WAIT_CYC)) u_fsm (
    .pclk     (pclk),
    .preset_n (preset_n),
    .psel     (psel),
    .penable  (penable),
    .pready   (pready),
    .complete (complete),
    .abort    (abort)
  );

  assign idx     = paddr[AW-1:LSB];
  assign idx_oob = {1'b0, idx} >= NREG_V;
  assign off_nz  = |(paddr & OFF_MASK);
  assign ro_ext  = RO_W'(RO_MASK);
  assign err     = acc_err(idx_oob, off_nz, pwrite, ro_ext[idx]);
  assign wr_en   = complete & pwrite & ~err;

  always_comb begin
    reg_d = reg_q;
    for (int i = 0; i < NREG; i++) begin
      if (wr_en && !RO_MASK[i] && idx == IW'(i)) begin
        for (int k = 0; k < NB; k++)
          if (pstrb[k]) reg_d[i][k*8 +: 8] = pwdata[k*8 +: 8];
      end
    end
  end

  // RO slots never load, so their reg_o slices stay at the reset value of 0.
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      for (int i = 0; i < NREG; i++) reg_q[i] <= RO_MASK[i] ? '0 : RST_VAL;
    end else begin
      reg_q <= reg_d;
    end
  end

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NREG; i++)
      if (idx == IW'(i)) rd_sel = RO_MASK[i] ? sts_i[i*DW +: DW] : reg_q[i];
  end

  assign prdata  = (pready && !pwrite && !err) ? rd_sel : '0;
  assign pslverr = pready & err;
  assign reg_o   = reg_q;

  logic unused_ok;
  assign unused_ok = ^{sts_i, abort};
endmodule
